// File: rtl/bullet_pkg.sv
// bullet_pkg: shared screen geometry, colour constants and the renderer FSM encoding.
package bullet_pkg;

    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_BONE  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

endpackage

// File: rtl/bullet_renderer_if.sv
// bullet_renderer_if: VGA-adapter pixel write port (one pixel per cycle when vga_plot=1).
interface bullet_renderer_if;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (output vga_x, output vga_y, output vga_colour, output vga_plot);
    modport slave  (input  vga_x, input  vga_y, input  vga_colour, input  vga_plot);

endinterface

// File: rtl/rect_scanner.sv
// rect_scanner: walks a BOX_W x BOX_H box row-major, one pixel per cycle.
// The origin is latched on start; pixel coordinates and the plot strobe are
// flop outputs so they can drive the VGA port directly. Coordinates are kept
// at 9/8 bits internally so the optional screen clip sees un-wrapped values.
module rect_scanner #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 8,
    parameter int LIM_X = 160,
    parameter int LIM_Y = 120,
    parameter bit CLIP  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic       pix_valid,
    output logic       done
);

    localparam int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(BOX_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(BOX_H - 1);
    localparam logic [8:0]    LX       = 9'(LIM_X);
    localparam logic [7:0]    LY       = 8'(LIM_Y);

    logic [8:0]    px, nx;
    logic [7:0]    py, ny;
    logic [7:0]    ox;
    logic [CW-1:0] col, ncol;
    logic [RW-1:0] row, nrow;
    logic          run, nrun;
    logic          plot, nplot;

    assign done      = run && (col == COL_LAST) && (row == ROW_LAST);
    assign pix_x     = px[7:0];
    assign pix_y     = py[6:0];
    assign pix_valid = plot;

    // next pixel: restart on start, else advance along the row and wrap to the next
    always_comb begin
        nx   = px;
        ny   = py;
        ncol = col;
        nrow = row;
        nrun = run;
        if (start) begin
            nx   = {1'b0, org_x};
            ny   = {1'b0, org_y};
            ncol = '0;
            nrow = '0;
            nrun = 1'b1;
        end else if (run) begin
            if (done) begin
                nrun = 1'b0;
            end else if (col == COL_LAST) begin
                ncol = '0;
                nrow = row + RW'(1);
                nx   = {1'b0, ox};
                ny   = py + 8'd1;
            end else begin
                ncol = col + CW'(1);
                nx   = px + 9'd1;
            end
        end
        // off-screen pixels still take their cycle but are not written when clipping
        nplot = nrun && (!CLIP || ((nx < LX) && (ny < LY)));
    end

    // walk registers, cleared asynchronously so a reset mid-scan stops plotting at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px   <= '0;
            py   <= '0;
            ox   <= '0;
            col  <= '0;
            row  <= '0;
            run  <= 1'b0;
            plot <= 1'b0;
        end else begin
            px   <= nx;
            py   <= ny;
            col  <= ncol;
            row  <= nrow;
            run  <= nrun;
            plot <= nplot;
            if (start) ox <= org_x;
        end
    end

endmodule

// File: rtl/bullet_renderer.sv
// bullet_renderer: redraws a bullet sprite whenever its position/active state
// changes: erase the old box in black, draw the new one, then test it against
// the player hitbox and raise a sticky collision flag.
// Optional build macro BULLET_RENDERER_CLIP_EN suppresses plots outside the screen.
module bullet_renderer
    import bullet_pkg::*;
#(
    parameter int SCREEN_WIDTH  = bullet_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = bullet_pkg::SCREEN_HEIGHT,
    parameter int BULLET_W      = 4,
    parameter int BULLET_H      = 8,
    parameter int PLAYER_W      = 8,
    parameter int PLAYER_H      = 8
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          bullet_x,
    input  logic [6:0]          bullet_y,
    input  logic                bullet_active,
    input  logic [2:0]          bullet_color,
    input  logic [7:0]          player_x,
    input  logic [6:0]          player_y,
    input  logic                clear_collision,
    bullet_renderer_if.master   vga,
    output logic                busy,
    output logic                player_collision
);

`ifdef BULLET_RENDERER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    state_t     state;
    logic [7:0] snap_x;
    logic [6:0] snap_y;
    logic       snap_act;
    logic [2:0] snap_col;
    logic       drawn;
    logic [2:0] colour;

    logic       chg, hit;
    logic       scan_start, scan_done, scan_valid;
    logic [7:0] org_x, scan_x;
    logic [6:0] org_y, scan_y;

    assign chg = {bullet_x, bullet_y, bullet_active} != {snap_x, snap_y, snap_act};

    // overlap test widened to 9 bits so x+width / y+height never wrap
    logic [8:0] bx9, by9, px9, py9;
    assign bx9 = {1'b0, snap_x};
    assign by9 = {2'b00, snap_y};
    assign px9 = {1'b0, player_x};
    assign py9 = {2'b00, player_y};
    assign hit = snap_act
              && (bx9 < px9 + 9'(PLAYER_W)) && (px9 < bx9 + 9'(BULLET_W))
              && (by9 < py9 + 9'(PLAYER_H)) && (py9 < by9 + 9'(BULLET_H));

    // scanner kick-off: erase starts at the old snapshot, draw at the new one
    always_comb begin
        scan_start = 1'b0;
        org_x      = snap_x;
        org_y      = snap_y;
        case (state)
            ST_IDLE: begin
                if (chg && (drawn || bullet_active)) begin
                    scan_start = 1'b1;
                    if (!drawn) begin
                        org_x = bullet_x;
                        org_y = bullet_y;
                    end
                end
            end
            ST_ERASE: scan_start = scan_done && snap_act;
            default:  scan_start = 1'b0;
        endcase
    end

    rect_scanner #(
        .BOX_W (BULLET_W),
        .BOX_H (BULLET_H),
        .LIM_X (SCREEN_WIDTH),
        .LIM_Y (SCREEN_HEIGHT),
        .CLIP  (CLIP)
    ) u_scan (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .start     (scan_start),
        .org_x     (org_x),
        .org_y     (org_y),
        .pix_x     (scan_x),
        .pix_y     (scan_y),
        .pix_valid (scan_valid),
        .done      (scan_done)
    );

    assign vga.vga_x      = scan_x;
    assign vga.vga_y      = scan_y;
    assign vga.vga_plot   = scan_valid;
    assign vga.vga_colour = colour;

    // sequencing FSM: snapshot capture, erase/draw ordering, collision flag
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state            <= ST_IDLE;
            snap_x           <= '0;
            snap_y           <= '0;
            snap_act         <= 1'b0;
            snap_col         <= '0;
            drawn            <= 1'b0;
            colour           <= COLOUR_BLACK;
            busy             <= 1'b0;
            player_collision <= 1'b0;
        end else begin
            if (clear_collision) player_collision <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (chg) begin
                        snap_x   <= bullet_x;
                        snap_y   <= bullet_y;
                        snap_act <= bullet_active;
                        snap_col <= bullet_color;
                        drawn    <= bullet_active;
                        busy     <= 1'b1;
                        if (drawn) begin
                            state  <= ST_ERASE;
                            colour <= COLOUR_BLACK;
                        end else if (bullet_active) begin
                            state  <= ST_DRAW;
                            colour <= bullet_color;
                        end else begin
                            state  <= ST_CHECK;
                            colour <= COLOUR_BLACK;
                        end
                    end
                end
                ST_ERASE: begin
                    if (scan_done) begin
                        if (snap_act) begin
                            state  <= ST_DRAW;
                            colour <= snap_col;
                        end else begin
                            state  <= ST_CHECK;
                            colour <= COLOUR_BLACK;
                        end
                    end
                end
                ST_DRAW: begin
                    if (scan_done) begin
                        state  <= ST_CHECK;
                        colour <= COLOUR_BLACK;
                    end
                end
                ST_CHECK: begin
                    // a hit in the same cycle as a clear leaves the flag set
                    if (hit) player_collision <= 1'b1;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bullet_renderer.md
BULLET_RENDERER -- requirements
Module: bullet_renderer

Interface
REQ-001 The module SHALL have parameter SCREEN_WIDTH, default 160, meaning framebuffer width in pixels.
REQ-002 The module SHALL have parameter SCREEN_HEIGHT, default 120, meaning framebuffer height in pixels.
REQ-003 The module SHALL have parameter BULLET_W, default 4, meaning bullet sprite width; BULLET_H, default 8, meaning bullet sprite height.
REQ-004 The module SHALL have parameter PLAYER_W, default 8, meaning player hitbox width; PLAYER_H, default 8, meaning player hitbox height.
REQ-005 The module SHALL have port CLOCK_50  in  1  system clock, the single clock; all logic on its rising edge.
REQ-006 The module SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-007 The module SHALL have ports bullet_x in 8, bullet_y in 7, bullet_active in 1 and bullet_color in 3: the bullet state from the upstream bullet generator.
REQ-008 The module SHALL have ports player_x in 8 and player_y in 7: the player hitbox top-left corner.
REQ-009 The module SHALL have port clear_collision  in  1: a single-cycle pulse that clears the collision flag.
REQ-010 The module SHALL have ports vga_x out 8, vga_y out 7, vga_colour out 3 and vga_plot out 1: the VGA-adapter pixel write port, one pixel per cycle when vga_plot=1.
REQ-011 The module SHALL have port busy  out  1: high whenever the FSM is not IDLE.
REQ-012 The module SHALL have port player_collision  out  1: sticky hit flag, fed back to the bullet generator.

Function
REQ-013 The FSM SHALL have states IDLE, ERASE, DRAW and CHECK.
REQ-014 In IDLE, when {bullet_x,bullet_y,bullet_active} differs from the last-drawn snapshot, the module SHALL capture a new snapshot and go to ERASE on the next edge.
REQ-015 ERASE SHALL scan the BULLET_W x BULLET_H box at the previous snapshot, row-major, one pixel per cycle, with vga_colour=3'b000; ERASE SHALL be skipped (go straight to DRAW) if no previous box was drawn.
REQ-016 DRAW SHALL scan the box at the new snapshot with the captured bullet_color; DRAW SHALL be skipped (go to CHECK) if the snapshot has bullet_active=0.
REQ-017 Defaults: ERASE takes 32 cycles, DRAW takes 32 cycles and CHECK takes 1 cycle; busy SHALL be high for the whole sequence.
REQ-018 In CHECK, the module SHALL set player_collision=1 when the snapshot is active and bx<px+PLAYER_W && px<bx+BULLET_W && by<py+PLAYER_H && py<by+BULLET_H; the compare SHALL be evaluated at 9 bits so that no term wraps. The FSM SHALL then return to IDLE.
REQ-019 Input changes during ERASE, DRAW or CHECK SHALL be ignored; the inputs are re-compared in IDLE.
REQ-020 player_collision SHALL stay high until a clear_collision pulse; if clear_collision coincides with a new hit in CHECK, the set SHALL win.
REQ-021 vga_x, vga_y, vga_colour and vga_plot SHALL be registered; vga_plot=0 in IDLE and CHECK.

Reset
REQ-022 Asserting resetn low SHALL force state=IDLE, all outputs=0, and the snapshot and previous-drawn flag cleared, including mid-scan; the first change after reset SHALL skip ERASE.

Configuration
REQ-023 With BULLET_RENDERER_CLIP_EN defined, pixels with x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT SHALL still consume a cycle but SHALL drive vga_plot=0; without it, they SHALL be plotted with coordinates truncated to port width.

Structure
REQ-024 Package bullet_pkg SHALL hold SCREEN_WIDTH/HEIGHT, COLOUR_BLACK=3'b000, COLOUR_BONE=3'b011 and the FSM state encoding.
REQ-025 Sub-module rect_scanner SHALL hold the box-walk counter, with inputs start/origin, outputs pixel x/y/valid and done; bullet_renderer SHALL instantiate it once.

Verification
REQ-026 After reset, bullet (61,0) active, colour 011 -> no ERASE; 32 plots at x 61..64, y 0..7 with colour 011; busy high for 33 cycles.
REQ-027 Bullet moves (61,0)->(61,1) -> 32 black plots at y 0..7, then 32 colour plots at y 1..8.
REQ-028 Player at (60,5), bullet at (61,0) -> player_collision=1 after CHECK; clear_collision pulse -> 0.
REQ-029 Bullet at (158,116) with CLIP_EN defined -> only the 8 in-screen pixels (x 158..159, y 116..119) have vga_plot=1.
REQ-030 resetn low at the 10th ERASE cycle -> vga_plot=0, busy=0 and player_collision=0 immediately; the next change does DRAW only.
REQ-031 bullet_active 1->0 -> ERASE of the old box, no DRAW, no collision.
